// File: rtl/phy_link_monitor_if.sv
// phy_link_monitor_if
// Management request/response bundle between phy_link_monitor (master) and
// phy_mdio (slave).
//   m_mdio_pa  PHY address            (master -> slave)
//   m_mdio_ra  register address       (master -> slave)
//   m_mdio_d   write data             (master -> slave)
//   m_mdio_rd  1 = read, 0 = write    (master -> slave)
//   m_mdio_dv  request valid          (master -> slave)
//   m_mdio_dr  slave ready / idle     (slave -> master)
//   s_mdio_d   read data              (slave -> master)
//   s_mdio_dv  read data valid pulse  (slave -> master)
interface phy_link_monitor_if;
    logic [4:0]  m_mdio_pa;
    logic [4:0]  m_mdio_ra;
    logic [15:0] m_mdio_d;
    logic        m_mdio_rd;
    logic        m_mdio_dv;
    logic        m_mdio_dr;
    logic [15:0] s_mdio_d;
    logic        s_mdio_dv;

    modport master (
        output m_mdio_pa, m_mdio_ra, m_mdio_d, m_mdio_rd, m_mdio_dv,
        input  m_mdio_dr, s_mdio_d, s_mdio_dv
    );

    modport slave (
        input  m_mdio_pa, m_mdio_ra, m_mdio_d, m_mdio_rd, m_mdio_dv,
        output m_mdio_dr, s_mdio_d, s_mdio_dv
    );
endinterface

// File: rtl/phy_link_monitor.sv
// phy_link_monitor
// Soft-resets one PHY through BMCR, waits for the reset bit to self-clear,
// then polls BMSR as a read pair every POLL_INTERVAL cycles and exports the
// link state.
//   clk          system clock
//   rst          asynchronous reset, active high
//   mdio         request/response port towards phy_mdio (master modport)
//   init_done    BMCR reset completed, polling active
//   init_err     BMCR reset bit never cleared; sticky until reset
//   link_up      BMSR bit 2 from the second read of the latest poll
//   link_change  one-cycle pulse when link_up toggles
//   bmsr         last BMSR value (second read of the pair)
//
// state        | meaning
// -------------+------------------------------------------------------
// ST_STARTUP   | post-reset delay before the first transaction
// ST_WR_BMCR   | write INIT_BMCR to reg 0
// ST_RD_BMCR   | read reg 0 until the soft-reset bit clears
// ST_RD_BMSR1  | read reg 1 and discard (clears latched-low link bit)
// ST_RD_BMSR2  | read reg 1 and publish the result
// ST_WAIT      | idle until the poll interval expires
// ST_ERROR     | soft reset never completed; no further requests
module phy_link_monitor #(
    parameter logic [4:0]  PHY_ADDR      = 5'd1,
    parameter logic [15:0] INIT_BMCR     = 16'h9140,
    parameter int unsigned STARTUP_DELAY = 1000,
    parameter int unsigned RESET_POLLS   = 16,
    parameter int unsigned POLL_INTERVAL = 1000000
) (
    input  logic                      clk,
    input  logic                      rst,
    phy_link_monitor_if.master        mdio,
    output logic                      init_done,
    output logic                      init_err,
    output logic                      link_up,
    output logic                      link_change,
    output logic [15:0]               bmsr
);
    localparam int unsigned TMR_MAX = (STARTUP_DELAY > POLL_INTERVAL) ? STARTUP_DELAY : POLL_INTERVAL;
    localparam int TW = $clog2(TMR_MAX + 1);
    localparam int PW = $clog2(RESET_POLLS + 1);
    localparam logic [TW-1:0] STARTUP_TC = TW'(STARTUP_DELAY - 1);
    localparam logic [TW-1:0] POLL_TC    = TW'(POLL_INTERVAL - 1);
    localparam logic [PW-1:0] POLLS_TC   = PW'(RESET_POLLS - 1);

    typedef enum logic [2:0] {
        ST_STARTUP, ST_WR_BMCR, ST_RD_BMCR, ST_RD_BMSR1, ST_RD_BMSR2, ST_WAIT, ST_ERROR
    } state_t;

    state_t        state_q;
    logic [TW-1:0] tmr_q;
    logic [PW-1:0] pc_q;
    logic          dv_q;
    logic          pend_q;
    logic [4:0]    ra_q;
    logic [15:0]   d_q;
    logic          rd_q;
    logic          init_done_q;
    logic          init_err_q;
    logic          link_up_q;
    logic          link_change_q;
    logic [15:0]   bmsr_q;

    logic          req_active;
    logic          req_rd;
    logic [4:0]    req_ra;
    logic          xfer_done;
    logic [TW-1:0] tmr_inc;

    always_comb begin
        req_active = 1'b0;
        req_rd     = 1'b1;
        req_ra     = 5'd0;
        case (state_q)
            ST_WR_BMCR:  begin req_active = 1'b1; req_rd = 1'b0; end
            ST_RD_BMCR:  req_active = 1'b1;
            ST_RD_BMSR1,
            ST_RD_BMSR2: begin req_active = 1'b1; req_ra = 5'd1; end
            default:     ;
        endcase
    end

    // Writes finish when phy_mdio goes idle again; reads finish on the data
    // pulse, so stray s_mdio_dv outside an accepted read is ignored.
    assign xfer_done = pend_q && (rd_q ? mdio.s_mdio_dv : mdio.m_mdio_dr);
    // The timer saturates so a stalled poll can never alias into a short one.
    assign tmr_inc   = (&tmr_q) ? tmr_q : tmr_q + TW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_STARTUP;
            tmr_q         <= '0;
            pc_q          <= '0;
            dv_q          <= 1'b0;
            pend_q        <= 1'b0;
            ra_q          <= 5'd0;
            d_q           <= 16'd0;
            rd_q          <= 1'b0;
            init_done_q   <= 1'b0;
            init_err_q    <= 1'b0;
            link_up_q     <= 1'b0;
            link_change_q <= 1'b0;
            bmsr_q        <= 16'd0;
        end else begin
            tmr_q         <= tmr_inc;
            link_change_q <= 1'b0;

            if (dv_q) begin
                if (!mdio.m_mdio_dr) begin
                    dv_q   <= 1'b0;
                    pend_q <= 1'b1;
                end
            end else if (!pend_q && req_active && mdio.m_mdio_dr) begin
                dv_q <= 1'b1;
                ra_q <= req_ra;
                rd_q <= req_rd;
                d_q  <= req_rd ? 16'd0 : INIT_BMCR;
            end
            if (xfer_done) begin
                pend_q <= 1'b0;
            end

            case (state_q)
                ST_STARTUP: begin
                    if (tmr_q == STARTUP_TC) begin
                        state_q <= ST_WR_BMCR;
                    end
                end
                ST_WR_BMCR: begin
                    if (xfer_done) begin
                        state_q <= ST_RD_BMCR;
                    end
                end
                ST_RD_BMCR: begin
                    if (xfer_done) begin
                        pc_q <= pc_q + PW'(1);
                        if (!mdio.s_mdio_d[15]) begin
                            init_done_q <= 1'b1;
                            tmr_q       <= '0;
                            state_q     <= ST_RD_BMSR1;
                        end else if (pc_q == POLLS_TC) begin
                            init_err_q <= 1'b1;
                            state_q    <= ST_ERROR;
                        end
                    end
                end
                ST_RD_BMSR1: begin
                    if (xfer_done) begin
                        state_q <= ST_RD_BMSR2;
                    end
                end
                ST_RD_BMSR2: begin
                    if (xfer_done) begin
                        bmsr_q        <= mdio.s_mdio_d;
                        link_up_q     <= mdio.s_mdio_d[2];
                        link_change_q <= mdio.s_mdio_d[2] ^ link_up_q;
                        // Interval measured from the start of RD_BMSR1; an
                        // overlong poll restarts immediately.
                        if (tmr_q >= POLL_TC) begin
                            tmr_q   <= '0;
                            state_q <= ST_RD_BMSR1;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (tmr_q >= POLL_TC) begin
                        tmr_q   <= '0;
                        state_q <= ST_RD_BMSR1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mdio.m_mdio_pa = PHY_ADDR;
    assign mdio.m_mdio_ra = ra_q;
    assign mdio.m_mdio_d  = d_q;
    assign mdio.m_mdio_rd = rd_q;
    assign mdio.m_mdio_dv = dv_q;
    assign init_done      = init_done_q;
    assign init_err       = init_err_q;
    assign link_up        = link_up_q;
    assign link_change    = link_change_q;
    assign bmsr           = bmsr_q;
endmodule

// File: tb/tb_phy_link_monitor.sv
// Bench for phy_link_monitor: a randomized phy_mdio responder plus a
// transaction-level model of the expected request sequence and status outputs.
module tb_phy_link_monitor;
    localparam int          SD = 20;
    localparam int          RP = 4;
    localparam int          PI = 200;
    localparam logic [4:0]  PA = 5'd1;
    localparam logic [15:0] IB = 16'h9140;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_done, init_err, link_up, link_change;
    logic [15:0] bmsr;

    phy_link_monitor_if bus();

    phy_link_monitor #(
        .PHY_ADDR(PA), .INIT_BMCR(IB), .STARTUP_DELAY(SD),
        .RESET_POLLS(RP), .POLL_INTERVAL(PI)
    ) dut (
        .clk(clk), .rst(rst), .mdio(bus),
        .init_done(init_done), .init_err(init_err), .link_up(link_up),
        .link_change(link_change), .bmsr(bmsr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // scenario configuration (written by the main sequence)
    int          n_busy = 0;          // BMCR reads that still show the reset bit
    logic [15:0] bmsr_tab[$];         // scripted BMSR responses, random after
    bit          hold_rst = 1'b0;     // stall acceptance of a later BMSR2 read
    bit          stray_en = 1'b0;     // inject s_mdio_dv outside reads
    int          rel_cyc = 0;

    // responder / model state (written only by the compare process)
    int          cyc = 0;
    int          ph = 0;
    int          acc_cnt, busy_cnt;
    logic [4:0]  cur_ra;
    logic        cur_rd;
    logic [15:0] cur_d;
    bit          cur_second;
    int          req_n, bmcr_rk, bmsr_rk, bmsr_req_seen, last_poll, lc_count, dv_cycles;
    logic [4:0]  log_ra[$];
    logic        log_rd[$];
    logic [15:0] log_d[$];
    logic        e_done, e_err, e_link, e_lc, n_done, n_err, n_link;
    logic [15:0] e_bmsr, n_bmsr;
    logic [4:0]  x_ra;
    logic        x_rd;
    logic [15:0] x_d, rsp;
    bit          ok;

    // Expected i-th request of an epoch: one write, then BMCR reads until the
    // reset bit clears (or RP of them), then endless BMSR reads if init passed.
    function automatic bit exp_req(input int i, output logic [4:0] ra, output logic rd,
                                   output logic [15:0] d);
        int l;
        l  = (n_busy + 1 < RP) ? n_busy + 1 : RP;
        ra = 5'd0; rd = 1'b1; d = 16'd0;
        if (i == 0) begin rd = 1'b0; d = IB; return 1'b1; end
        if (i <= l) return 1'b1;
        ra = 5'd1;
        return (n_busy + 1 <= RP);
    endfunction

    function automatic int count_req(input logic [4:0] ra, input logic rd);
        int c = 0;
        for (int i = 0; i < log_ra.size(); i++)
            if (log_ra[i] == ra && log_rd[i] == rd) c++;
        return c;
    endfunction

    // compare process + phy_mdio responder
    initial begin
        bus.m_mdio_dr = 1'b1;
        bus.s_mdio_dv = 1'b0;
        bus.s_mdio_d  = 16'd0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            bus.s_mdio_dv = 1'b0;
            if (rst) begin
                ph = 0; bus.m_mdio_dr = 1'b1;
                req_n = 0; bmcr_rk = 0; bmsr_rk = 0; bmsr_req_seen = 0; last_poll = -1;
                lc_count = 0; dv_cycles = 0;
                log_ra.delete(); log_rd.delete(); log_d.delete();
                e_done = 0; e_err = 0; e_link = 0; e_bmsr = 0;
                n_done = 0; n_err = 0; n_link = 0; n_bmsr = 0;
                check("rst_dv", bus.m_mdio_dv, 0);
                check("rst_ra", bus.m_mdio_ra, 0);
                check("rst_d", bus.m_mdio_d, 0);
                check("rst_rd", bus.m_mdio_rd, 0);
                check("rst_pa", bus.m_mdio_pa, PA);
                check("rst_outs", {init_done, init_err, link_up, link_change, bmsr}, 0);
                continue;
            end
            e_lc = (n_link != e_link);
            e_done = n_done; e_err = n_err; e_link = n_link; e_bmsr = n_bmsr;
            check("init_done", init_done, e_done);
            check("init_err", init_err, e_err);
            check("link_up", link_up, e_link);
            check("link_change", link_change, e_lc);
            check("bmsr", bmsr, e_bmsr);
            check("pa", bus.m_mdio_pa, PA);
            if (bus.m_mdio_dv) dv_cycles++;
            if (link_change) lc_count++;

            if (stray_en && $urandom_range(0, 7) == 0 &&
                ((ph == 0 && !bus.m_mdio_dv) || (ph == 2 && !cur_rd))) begin
                bus.s_mdio_dv = 1'b1;
                bus.s_mdio_d  = 16'($urandom);
            end

            if (ph == 0 && bus.m_mdio_dv) begin
                cur_ra = bus.m_mdio_ra; cur_rd = bus.m_mdio_rd; cur_d = bus.m_mdio_d;
                if (req_n == 0)
                    check("startup_delay", (cyc - rel_cyc >= SD) && (cyc - rel_cyc <= SD + 2), 1);
                cur_second = 1'b0;
                if (cur_ra == 5'd1) begin
                    if (bmsr_req_seen % 2 == 0) begin
                        if (last_poll >= 0) check("poll_spacing", cyc - last_poll, PI);
                        last_poll = cyc;
                    end else begin
                        cur_second = 1'b1;
                    end
                    bmsr_req_seen++;
                end
                acc_cnt = (hold_rst && cur_second && bmsr_rk >= 2) ? 1000000 : $urandom_range(0, 2);
                ph = 1;
            end

            if (ph == 1) begin
                check("dv_held", bus.m_mdio_dv, 1);
                check("ra_stable", bus.m_mdio_ra, cur_ra);
                check("rd_stable", bus.m_mdio_rd, cur_rd);
                check("d_stable", bus.m_mdio_d, cur_d);
                if (acc_cnt == 0) begin
                    bus.m_mdio_dr = 1'b0;
                    ok = exp_req(req_n, x_ra, x_rd, x_d);
                    check("req_allowed", ok, 1);
                    if (ok) begin
                        check("req_ra", cur_ra, x_ra);
                        check("req_rd", cur_rd, x_rd);
                        if (!x_rd) check("req_d", cur_d, x_d);
                    end
                    log_ra.push_back(cur_ra); log_rd.push_back(cur_rd); log_d.push_back(cur_d);
                    req_n++;
                    busy_cnt = $urandom_range(2, 8);
                    ph = 2;
                end else begin
                    acc_cnt--;
                end
            end else if (ph == 2) begin
                check("single_outstanding", bus.m_mdio_dv, 0);
                if (busy_cnt == 0) begin
                    bus.m_mdio_dr = 1'b1;
                    if (cur_rd) begin
                        if (cur_ra == 5'd0) begin
                            rsp = (bmcr_rk < n_busy) ? 16'h9140 : 16'h1140;
                            if (!rsp[15]) n_done = 1'b1;
                            else if (bmcr_rk + 1 == RP) n_err = 1'b1;
                            bmcr_rk++;
                        end else begin
                            rsp = (bmsr_rk < bmsr_tab.size()) ? bmsr_tab[bmsr_rk] : 16'($urandom);
                            if (bmsr_rk % 2 == 1) begin n_bmsr = rsp; n_link = rsp[2]; end
                            bmsr_rk++;
                        end
                        bus.s_mdio_d  = rsp;
                        bus.s_mdio_dv = 1'b1;
                    end
                    ph = 0;
                end else begin
                    busy_cnt--;
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic wait_bmsr(input string name, input int n, input int budget);
        int k = 0;
        while (bmsr_rk < n && k < budget) begin @(posedge clk); k++; end
        #3;
        if (bmsr_rk < n) check(name, bmsr_rk, n);
        wait_cyc(2);
    endtask

    task automatic wait_bmcr(input string name, input int n, input int budget);
        int k = 0;
        while (bmcr_rk < n && k < budget) begin @(posedge clk); k++; end
        #3;
        if (bmcr_rk < n) check(name, bmcr_rk, n);
        wait_cyc(2);
    endtask

    initial begin
        int k, d0;
        // single BMCR read, then polling
        n_busy = 0; bmsr_tab.delete();
        do_reset();
        wait_bmsr("A_timeout", 6, 3000);
        check("A_writes", count_req(5'd0, 1'b0), 1);
        check("A_write_d", log_d[0], 16'h9140);
        check("A_write_ra", log_ra[0], 0);
        check("A_bmcr_reads", count_req(5'd0, 1'b1), 1);
        check("A_init_done", init_done, 1);
        check("A_nreq", log_ra.size() >= 3, 1);
        check("A_req2_ra", log_ra[2], 1);
        check("A_req2_rd", log_rd[2], 1);

        // reset bit clears on the fourth read
        n_busy = 3;
        do_reset();
        wait_bmsr("B_timeout", 2, 3000);
        check("B_bmcr_reads", count_req(5'd0, 1'b1), 4);
        check("B_init_err", init_err, 0);
        check("B_init_done", init_done, 1);

        // reset bit never clears
        n_busy = 100;
        do_reset();
        wait_bmcr("C_timeout", 4, 3000);
        check("C_init_err", init_err, 1);
        check("C_init_done", init_done, 0);
        d0 = dv_cycles;
        wait_cyc(10 * PI);
        check("C_quiet_dv", dv_cycles - d0, 0);
        check("C_bmcr_reads", count_req(5'd0, 1'b1), 4);
        check("C_nreq", log_ra.size(), 5);

        // link up then down
        n_busy = 0; bmsr_tab.delete();
        bmsr_tab.push_back(16'h7849); bmsr_tab.push_back(16'h786D);
        bmsr_tab.push_back(16'h7849); bmsr_tab.push_back(16'h7849);
        do_reset();
        wait_bmsr("D1_timeout", 2, 3000);
        check("D1_bmsr", bmsr, 16'h786D);
        check("D1_link", link_up, 1);
        check("D1_pulses", lc_count, 1);
        wait_bmsr("D2_timeout", 4, 3000);
        check("D2_bmsr", bmsr, 16'h7849);
        check("D2_link", link_up, 0);
        check("D2_pulses", lc_count, 2);

        // identical BMSR over 5 polls, exact spacing checked per poll
        bmsr_tab.delete();
        for (int i = 0; i < 10; i++) bmsr_tab.push_back(16'h7849);
        do_reset();
        wait_bmsr("E_timeout", 10, 4000);
        check("E_pulses", lc_count, 0);
        check("E_polls", bmsr_req_seen >= 10, 1);

        // randomized runs with stray read-valid pulses
        stray_en = 1'b1;
        bmsr_tab.delete();
        for (int r = 0; r < 4; r++) begin
            n_busy = $urandom_range(0, 5);
            do_reset();
            if (n_busy + 1 <= RP) begin
                wait_bmsr("F_timeout", 16, 5000);
                check("F_init_done", init_done, 1);
            end else begin
                wait_bmcr("F_timeout", RP, 3000);
                wait_cyc(300);
                check("F_init_err", init_err, 1);
            end
        end
        stray_en = 1'b0;

        // reset while a later BMSR2 request is held
        n_busy = 0; bmsr_tab.delete();
        for (int i = 0; i < 8; i++) bmsr_tab.push_back(16'h786D);
        hold_rst = 1'b1;
        do_reset();
        k = 0;
        while (!(ph == 1 && cur_second && bmsr_rk >= 2) && k < 3000) begin @(posedge clk); k++; end
        wait_cyc(3);
        check("G_held", ph == 1 && cur_second && bmsr_rk >= 2, 1);
        check("G_link_before", link_up, 1);
        check("G_dv_before", bus.m_mdio_dv, 1);
        rst = 1'b1;
        #1;
        check("G_async_dv", bus.m_mdio_dv, 0);
        check("G_async_bus", {bus.m_mdio_ra, bus.m_mdio_d, bus.m_mdio_rd}, 0);
        check("G_async_outs", {init_done, init_err, link_up, link_change, bmsr}, 0);
        check("G_async_pa", bus.m_mdio_pa, PA);
        wait_cyc(2);
        hold_rst = 1'b0;
        rst = 1'b0;
        rel_cyc = cyc;
        k = 0;
        while (req_n < 1 && k < 500) begin @(posedge clk); k++; end
        #3;
        check("G_restart_req", req_n >= 1, 1);
        check("G_restart_ra", log_ra[0], 0);
        check("G_restart_rd", log_rd[0], 0);
        check("G_restart_d", log_d[0], 16'h9140);
        wait_bmsr("G_timeout", 2, 3000);
        check("G_link_after", link_up, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_chk);
        $fatal(1);
    end
endmodule

// File: doc/phy_link_monitor.md
Name: phy_link_monitor

Overview:
- Management sequencer directly upstream of phy_mdio; drives its slave request port (PHY address, register address, data, dv/rd) and consumes its read result port (data, dv).
- After reset it soft-resets and configures one PHY via BMCR (reg 0), then polls BMSR (reg 1) periodically.
- Exports link status, init status and a link-change pulse to the SR2CB ring logic.

Parameters:
PHY_ADDR, 5'd1, MDIO PHY address driven on m_mdio_pa.
INIT_BMCR, 16'h9140, BMCR value written at init; bit 15 (soft reset) must be set.
STARTUP_DELAY, 1000, clk cycles to wait after reset before the first transaction (min 1).
RESET_POLLS, 16, max BMCR reads waiting for bit 15 to clear (min 1).
POLL_INTERVAL, 1000000, clk cycles between BMSR poll starts (min 64).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active high
m_mdio_pa  out  5  PHY address to phy_mdio, constant PHY_ADDR
m_mdio_ra  out  5  register address to phy_mdio
m_mdio_d  out  16  write data to phy_mdio
m_mdio_rd  out  1  1 = read, 0 = write
m_mdio_dv  out  1  request valid
m_mdio_dr  in  1  phy_mdio ready (idle)
s_mdio_d  in  16  read data from phy_mdio
s_mdio_dv  in  1  read data valid, one clk pulse
init_done  out  1  BMCR reset completed, polling active
init_err  out  1  BMCR bit 15 still set after RESET_POLLS reads; sticky until reset
link_up  out  1  BMSR bit 2 from the second read of the latest poll
link_change  out  1  one clk pulse when link_up toggles
bmsr  out  16  last BMSR value (second read)

Behaviour:
- Reset (async assert, synchronous release): all outputs 0 except m_mdio_pa = PHY_ADDR; state STARTUP; counters cleared.
- Request handshake: set ra/d/rd, then assert m_mdio_dv only while m_mdio_dr = 1.
  - Hold m_mdio_dv until m_mdio_dr is sampled 0 (accepted), then deassert on the next clk.
  - ra/d/rd stay stable from dv assertion until acceptance.
- Write complete: m_mdio_dr returns to 1.
- Read complete: s_mdio_dv = 1; capture s_mdio_d that cycle. s_mdio_dv outside a read is ignored.
- States:
  - STARTUP: count STARTUP_DELAY cycles -> WR_BMCR.
  - WR_BMCR: write INIT_BMCR to reg 0 -> RD_BMCR on completion.
  - RD_BMCR: read reg 0; poll counter +1.
    - bit15 = 0 -> set init_done, load interval counter -> RD_BMSR1.
    - bit15 = 1 and count < RESET_POLLS -> read again.
    - bit15 = 1 and count = RESET_POLLS -> set init_err -> ERROR.
  - ERROR: terminal; no further requests, m_mdio_dv = 0.
  - RD_BMSR1: read reg 1 and discard (clears latched-low link bit) -> RD_BMSR2.
  - RD_BMSR2: read reg 1; update bmsr and link_up = bit 2; pulse link_change the cycle after the update if the value differs -> WAIT.
  - WAIT: interval counter counts from the start of RD_BMSR1; at POLL_INTERVAL cycles -> RD_BMSR1. If the poll took longer than POLL_INTERVAL, restart immediately after RD_BMSR2.
- Interval counter width: $clog2(POLL_INTERVAL+1); saturates, never wraps.
- m_mdio_dr = 0 while a request is pending: wait, no timeout (phy_mdio always returns to ready).
- rst mid-transaction: state machine returns to STARTUP immediately; phy_mdio is reset by the same reset domain.
- Never issues a new request before the previous one completes; at most one outstanding.

Test Plan:
- Reset release, PHY model returns BMCR 16'h1140 on first read -> exactly 1 write (ra = 0, d = 16'h9140) after STARTUP_DELAY, then 1 read ra = 0; init_done = 1; next request is read ra = 1.
- BMCR reads return 16'h9140 three times, then 16'h1140 -> 4 BMCR reads; init_done set after the 4th; init_err = 0.
- BMCR always 16'h9140, RESET_POLLS = 4 -> exactly 4 reads; init_err = 1; no further m_mdio_dv for 10*POLL_INTERVAL; init_done = 0.
- BMSR pair returns 16'h7849 then 16'h786D -> bmsr = 16'h786D, link_up = 1, one link_change pulse; next poll 16'h7849/16'h7849 -> link_up = 0, one pulse.
- Identical BMSR over 5 polls -> no link_change; poll starts spaced exactly POLL_INTERVAL cycles (POLL_INTERVAL = 200).
- Assert rst while RD_BMSR2 dv is held -> all outputs 0 in the same cycle; after release the sequence restarts with the BMCR write.
